pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard unit (slave).
// Latency/backpressure: plain wires; the stall/flush outputs are the pipeline's backpressure.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  raddr1D, raddr2D;
  logic [4:0]  raddr1E, raddr2E;
  logic [4:0]  waddrE, waddrM, waddrW;
  logic        reg_wrE, reg_wrM, reg_wrW;
  logic [1:0]  wb_selE;
  logic        br_takenE;
  logic        mc_startE;
  logic        StallF, StallD, StallE;
  logic        FlushD, FlushE, FlushM;
  logic [1:0]  fwd_AE, fwd_BE;
  logic        mc_busy;
  logic [31:0] stall_cycles;

  modport master (
    output raddr1D, raddr2D, raddr1E, raddr2E, waddrE, waddrM, waddrW,
           reg_wrE, reg_wrM, reg_wrW, wb_selE, br_takenE, mc_startE,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
           fwd_AE, fwd_BE, mc_busy, stall_cycles
  );

  modport slave (
    input  raddr1D, raddr2D, raddr1E, raddr2E, waddrE, waddrM, waddrW,
           reg_wrE, reg_wrM, reg_wrW, wb_selE, br_takenE, mc_startE,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
           fwd_AE, fwd_BE, mc_busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard unit: stall/flush/forward plus multi-cycle EX wait; HAZARD_FWD_EN enables forwarding.
// Latency: stall/flush/forward combinational, state registered; backpressure is the stall/flush outputs.
module pipeline_hazard_ctrl #(
  parameter int MC_LAT = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  localparam logic [4:0] MC_LOAD = 5'(MC_LAT - 2);

  state_t      state, state_nxt;
  logic [4:0]  mc_cnt, mc_cnt_nxt;
  logic [31:0] stall_cnt;
  logic        stall_f, stall_d, stall_e;
  logic        flush_d, flush_e, flush_m;
  logic [1:0]  fwd_a, fwd_b;
  logic        d_hazard;

`ifdef HAZARD_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] ra,
                                         input logic wr_m, input logic [4:0] wa_m,
                                         input logic wr_w, input logic [4:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && wa_m != 5'd0 && wa_m == ra)
      sel = 2'b10;
    else if (wr_w && wa_w != 5'd0 && wa_w == ra)
      sel = 2'b01;
    return sel;
  endfunction

  // Only a load in E cannot be forwarded in time; everything else is bypassed.
  assign d_hazard = hz.reg_wrE && hz.wb_selE == 2'b10 && hz.waddrE != 5'd0 &&
                    (hz.waddrE == hz.raddr1D || hz.waddrE == hz.raddr2D);
`else
  logic unused_fwd_in;
  assign unused_fwd_in = ^{hz.wb_selE, hz.raddr1E, hz.raddr2E, hz.waddrW, hz.reg_wrW};

  // No bypass paths: any pending write in E or M must drain before D reads.
  assign d_hazard =
      (hz.raddr1D != 5'd0 && ((hz.reg_wrE && hz.raddr1D == hz.waddrE) ||
                              (hz.reg_wrM && hz.raddr1D == hz.waddrM))) ||
      (hz.raddr2D != 5'd0 && ((hz.reg_wrE && hz.raddr2D == hz.waddrE) ||
                              (hz.reg_wrM && hz.raddr2D == hz.waddrM)));
`endif

  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_m    = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    state_nxt  = state;
    mc_cnt_nxt = mc_cnt;
    if (!rst) begin
`ifdef HAZARD_FWD_EN
      fwd_a = fwd_sel(hz.raddr1E, hz.reg_wrM, hz.waddrM, hz.reg_wrW, hz.waddrW);
      fwd_b = fwd_sel(hz.raddr2E, hz.reg_wrM, hz.waddrM, hz.reg_wrW, hz.waddrW);
`endif
      case (state)
        RUN: begin
          if (hz.br_takenE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (d_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
          if (hz.mc_startE && !hz.br_takenE) begin
            state_nxt  = MC_WAIT;
            mc_cnt_nxt = MC_LOAD;
          end
        end
        MC_WAIT: begin
          // Freeze F/D/E around the busy unit and feed bubbles into MEM.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          if (mc_cnt == 5'd0)
            state_nxt = RUN;
          else
            mc_cnt_nxt = mc_cnt - 5'd1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      mc_cnt    <= 5'd0;
      stall_cnt <= 32'd0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
      if (stall_f)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.StallF       = stall_f;
  assign hz.StallD       = stall_d;
  assign hz.StallE       = stall_e;
  assign hz.FlushD       = flush_d;
  assign hz.FlushE       = flush_e;
  assign hz.FlushM       = flush_m;
  assign hz.fwd_AE       = fwd_a;
  assign hz.fwd_BE       = fwd_b;
  assign hz.mc_busy      = (state == MC_WAIT) && !rst;
  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MC_LAT=4); expectations follow HAZARD_FWD_EN if defined.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(.MC_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, mc_busy}
  logic [6:0] outs;
  assign outs = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM, hz.mc_busy};

  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_STALL = 7'b1100100;
  localparam logic [6:0] O_BR   = 7'b0001100;
  localparam logic [6:0] O_MC   = 7'b1110011;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.raddr1D = 5'd0; hz.raddr2D = 5'd0;
    hz.raddr1E = 5'd0; hz.raddr2E = 5'd0;
    hz.waddrE = 5'd0; hz.waddrM = 5'd0; hz.waddrW = 5'd0;
    hz.reg_wrE = 1'b0; hz.reg_wrM = 1'b0; hz.reg_wrW = 1'b0;
    hz.wb_selE = 2'b00;
    hz.br_takenE = 1'b0;
    hz.mc_startE = 1'b0;
  endtask

  task automatic set_load_use();
    hz.reg_wrE = 1'b1; hz.wb_selE = 2'b10; hz.waddrE = 5'd5; hz.raddr1D = 5'd5;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    tick();
    tick();

    // Reset forces outputs low whatever the inputs say
    set_load_use();
    hz.reg_wrM = 1'b1; hz.waddrM = 5'd7; hz.raddr2E = 5'd7;
    #1;
    check("rst_outs", 32'(outs), 32'(O_IDLE));
    check("rst_fwdB", 32'(hz.fwd_BE), 32'd0);
    check("rst_cnt", hz.stall_cycles, 32'd0);

    clear_in();
    rst = 1'b0;
    tick();
    check("idle_outs", 32'(outs), 32'(O_IDLE));
    check("idle_cnt", hz.stall_cycles, 32'd0);

    // Load-use: one bubble, counted once
    set_load_use();
    #1;
    check("lu_outs", 32'(outs), 32'(O_STALL));
    tick();
    clear_in();
    #1;
    check("lu_after", 32'(outs), 32'(O_IDLE));
    check("lu_cnt", hz.stall_cycles, 32'd1);

    // x0 destination never hazards
    hz.reg_wrE = 1'b1; hz.wb_selE = 2'b10; hz.waddrE = 5'd0; hz.raddr1D = 5'd0;
    #1;
    check("x0_outs", 32'(outs), 32'(O_IDLE));
    clear_in();

    // W-stage write is never a D hazard
    hz.reg_wrW = 1'b1; hz.waddrW = 5'd6; hz.raddr1D = 5'd6;
    #1;
    check("w_nohaz", 32'(outs), 32'(O_IDLE));
    clear_in();

    // ALU result in E: bypassed with forwarding, stalls without
    hz.reg_wrE = 1'b1; hz.wb_selE = 2'b00; hz.waddrE = 5'd9; hz.raddr2D = 5'd9;
    #1;
    check("alu_e", 32'(outs), FWD ? 32'(O_IDLE) : 32'(O_STALL));
    clear_in();

    // M write vs D read: RAW stall only without forwarding; E operand forwards from M
    hz.reg_wrM = 1'b1; hz.waddrM = 5'd3; hz.raddr1D = 5'd3; hz.raddr1E = 5'd3;
    #1;
    check("m_raw", 32'(outs), FWD ? 32'(O_IDLE) : 32'(O_STALL));
    check("m_fwdA", 32'(hz.fwd_AE), FWD ? 32'd2 : 32'd0);
    clear_in();

    // Forward priority M over W, then W, then x0
    hz.reg_wrM = 1'b1; hz.waddrM = 5'd7; hz.reg_wrW = 1'b1; hz.waddrW = 5'd7; hz.raddr2E = 5'd7;
    #1;
    check("fwdB_m", 32'(hz.fwd_BE), FWD ? 32'd2 : 32'd0);
    hz.reg_wrM = 1'b0;
    #1;
    check("fwdB_w", 32'(hz.fwd_BE), FWD ? 32'd1 : 32'd0);
    hz.raddr2E = 5'd0;
    #1;
    check("fwdB_x0", 32'(hz.fwd_BE), 32'd0);
    hz.raddr1E = 5'd7;
    #1;
    check("fwdA_w", 32'(hz.fwd_AE), FWD ? 32'd1 : 32'd0);
    clear_in();

    // Branch beats load-use
    set_load_use();
    hz.br_takenE = 1'b1;
    #1;
    check("br_lu", 32'(outs), 32'(O_BR));
    clear_in();
    tick();

    // Branch cancels a multi-cycle start
    hz.br_takenE = 1'b1; hz.mc_startE = 1'b1;
    #1;
    check("br_mc", 32'(outs), 32'(O_BR));
    tick();
    clear_in();
    #1;
    check("br_mc_run", 32'(outs), 32'(O_IDLE));
    check("br_mc_cnt", hz.stall_cycles, 32'd1);

    // Multi-cycle op: 3 wait cycles at MC_LAT=4
    hz.mc_startE = 1'b1;
    #1;
    check("mc_start", 32'(outs), 32'(O_IDLE));
    tick();
    clear_in();
    #1;
    check("mc_w1", 32'(outs), 32'(O_MC));
    tick();
    set_load_use();
    hz.br_takenE = 1'b1; hz.mc_startE = 1'b1;
    #1;
    check("mc_w2", 32'(outs), 32'(O_MC));
    tick();
    clear_in();
    #1;
    check("mc_w3", 32'(outs), 32'(O_MC));
    tick();
    check("mc_done", 32'(outs), 32'(O_IDLE));
    check("mc_cnt", hz.stall_cycles, 32'd4);

    // Reset during the second wait cycle
    hz.mc_startE = 1'b1;
    tick();
    clear_in();
    #1;
    check("rmc_w1", 32'(outs), 32'(O_MC));
    tick();
    check("rmc_cnt_pre", hz.stall_cycles, 32'd5);
    rst = 1'b1;
    #1;
    check("rmc_rst_outs", 32'(outs), 32'(O_IDLE));
    tick();
    rst = 1'b0;
    #1;
    check("rmc_after", 32'(outs), 32'(O_IDLE));
    check("rmc_cnt", hz.stall_cycles, 32'd0);
    tick();
    check("rmc_stay", 32'(outs), 32'(O_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
